// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/read-data back.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction and computes next-PC.
// Optional fetch timeout with sticky error state is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCsrc,
    input  logic [1:0]        jPC,
    input  logic [31:0]       branch_imm,
    input  logic [25:0]       jump_idx,
    input  logic [31:0]       reg_target,
    input  logic              advance,
    pc_fetch_unit_if.master   imem,
    output logic [31:0]       instr,
    output logic [5:0]        OPC,
    output logic [5:0]        func,
    output logic              instr_valid,
    output logic [31:0]       PC,
    output logic [31:0]       PC_plus4,
    output logic              fetch_err
);

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;
`endif

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        valid_r;
    logic        req_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        unused_s;

    assign pc_plus4_s     = pc_r + 32'd4;
    // Low target bits and the shifted-out immediate bits never reach the PC.
    assign unused_s       = ^{reg_target[1:0], branch_imm[31:30], (TIMEOUT_CYC > 0)};

    // Next-PC select: J-type, then jump-register, then taken branch, else sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        case (jPC)
            2'b01:   next_pc_s = {pc_plus4_s[31:28], jump_idx, 2'b00};
            2'b10:   next_pc_s = {reg_target[31:2], 2'b00};
            default: begin
                if (PCsrc) begin
                    next_pc_s = pc_plus4_s + {branch_imm[29:0], 2'b00};
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
        endcase
    end

    // Fetch FSM with registered request, instruction, valid and PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            req_r   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_r   <= '0;
            err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        instr_r <= imem.imem_rdata;
                        valid_r <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= ST_VALID;
`ifdef FETCH_TIMEOUT_EN
                        cnt_r   <= '0;
                    end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err_r   <= 1'b1;
                        req_r   <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= ST_ERR;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
`else
                    end else begin
                        req_r   <= 1'b1;
`endif
                    end
                end
                ST_VALID: begin
                    if (advance) begin
                        pc_r    <= next_pc_s;
                        valid_r <= 1'b0;
                        req_r   <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_VALID;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                ST_ERR: begin
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign instr          = instr_r;
    assign OPC            = instr_r[31:26];
    assign func           = instr_r[5:0];
    assign instr_valid    = valid_r;
    assign PC             = pc_r;
    assign PC_plus4       = pc_plus4_s;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err      = err_r;
`else
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branches, jumps, wrap, stalls, reset, timeout.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        PCsrc;
    logic [1:0]  jPC;
    logic [31:0] branch_imm;
    logic [25:0] jump_idx;
    logic [31:0] reg_target;
    logic        advance;
    logic        ready_r;
    logic [31:0] instr;
    logic [5:0]  OPC;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        fetch_err;
    int          checks_cnt;
    int          errors_cnt;

    pc_fetch_unit_if bus ();

    // Memory model: each word is its address XOR a fixed pattern.
    assign bus.imem_ready = ready_r;
    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_BEEF;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCsrc      (PCsrc),
        .jPC        (jPC),
        .branch_imm (branch_imm),
        .jump_idx   (jump_idx),
        .reg_target (reg_target),
        .advance    (advance),
        .imem       (bus.master),
        .instr      (instr),
        .OPC        (OPC),
        .func       (func),
        .instr_valid(instr_valid),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // At a FETCH negedge with ready high: verify fetch, verify captured word, then advance.
    task automatic step(input logic [31:0] addr, input logic [1:0] jpc, input logic pcsrc,
                        input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] tgt);
        check_eq("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("fetch_addr", bus.imem_addr, addr);
        check_eq("fetch_novalid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_eq("valid", {31'd0, instr_valid}, 32'd1);
        check_eq("valid_noreq", {31'd0, bus.imem_req}, 32'd0);
        check_eq("instr", instr, addr ^ 32'hDEAD_BEEF);
        check_eq("pc", PC, addr);
        check_eq("pc_plus4", PC_plus4, addr + 32'd4);
        jPC        = jpc;
        PCsrc      = pcsrc;
        branch_imm = imm;
        jump_idx   = idx;
        reg_target = tgt;
        advance    = 1'b1;
        @(negedge clk);
        advance    = 1'b0;
        jPC        = 2'b00;
        PCsrc      = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        PCsrc      = 1'b0;
        jPC        = 2'b00;
        branch_imm = 32'd0;
        jump_idx   = 26'd0;
        reg_target = 32'd0;
        advance    = 1'b0;
        ready_r    = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_pc", PC, 32'h0000_0000);
        check_eq("rst_instr", instr, 32'h0000_0000);
        check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
        rst_n = 1'b1;
        check_eq("idle_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);

        check_eq("opc_pre", {26'd0, OPC}, 32'd0);
        step(32'h0000_0000, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        check_eq("opc", {26'd0, OPC}, 32'h37);
        check_eq("func", {26'd0, func}, 32'h2F);
        step(32'h0000_0004, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        step(32'h0000_0008, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        step(32'h0000_000C, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        step(32'h0000_0010, 2'b10, 1'b0, 32'd0, 26'd0, 32'h0000_0103);
        step(32'h0000_0100, 2'b00, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0);
        step(32'h0000_00FC, 2'b10, 1'b0, 32'd0, 26'd0, 32'h1000_0041);
        step(32'h1000_0040, 2'b01, 1'b0, 32'd0, 26'h0000123, 32'd0);
        step(32'h1000_048C, 2'b10, 1'b0, 32'd0, 26'd0, 32'h0000_2003);
        step(32'h0000_2000, 2'b11, 1'b1, 32'h0000_0004, 26'd0, 32'd0);
        step(32'h0000_2014, 2'b01, 1'b1, 32'h0000_0100, 26'h3FF_FFFF, 32'd0);
        step(32'h0FFF_FFFC, 2'b10, 1'b0, 32'd0, 26'd0, 32'hFFFF_FFFF);
        step(32'hFFFF_FFFC, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        step(32'h0000_0000, 2'b00, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0);

        // Stall: ready low for three FETCH cycles, advance held high but ignored.
        ready_r = 1'b0;
        advance = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_addr", bus.imem_addr, 32'hFFFF_FFFC);
            check_eq("stall_req", {31'd0, bus.imem_req}, 32'd1);
            check_eq("stall_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        ready_r = 1'b1;
        advance = 1'b0;
        @(negedge clk);
        ready_r = 1'b0;
        check_eq("stall_capture", instr, 32'h2152_4113);
        check_eq("stall_cvalid", {31'd0, instr_valid}, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("hold_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("hold_pc", PC, 32'hFFFF_FFFC);
        check_eq("hold_instr", instr, 32'h2152_4113);
        jPC        = 2'b10;
        reg_target = 32'h0000_0040;
        advance    = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        jPC     = 2'b00;
        check_eq("pre_rst_addr", bus.imem_addr, 32'h0000_0040);
        check_eq("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);

        // Reset mid-FETCH with a ready pulse during reset.
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req", {31'd0, bus.imem_req}, 32'd0);
        check_eq("midrst_pc", PC, 32'h0000_0000);
        ready_r = 1'b1;
        repeat (2) @(negedge clk);
        ready_r = 1'b0;
        check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("midrst_instr", instr, 32'h0000_0000);
        rst_n = 1'b1;
        check_eq("rel_idle_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        check_eq("rel_req", {31'd0, bus.imem_req}, 32'd1);
        check_eq("rel_addr", bus.imem_addr, 32'h0000_0000);

        // Ready held low from the first FETCH cycle.
        repeat (15) @(negedge clk);
        check_eq("to_pre_err", {31'd0, fetch_err}, 32'd0);
        check_eq("to_pre_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        check_eq("to_err", {31'd0, fetch_err}, 32'd1);
        check_eq("to_req", {31'd0, bus.imem_req}, 32'd0);
        ready_r = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("to_err_hold", {31'd0, fetch_err}, 32'd1);
        check_eq("to_req_hold", {31'd0, bus.imem_req}, 32'd0);
        check_eq("to_valid_hold", {31'd0, instr_valid}, 32'd0);
`else
        check_eq("noto_err", {31'd0, fetch_err}, 32'd0);
        check_eq("noto_req", {31'd0, bus.imem_req}, 32'd1);
        repeat (8) @(negedge clk);
        check_eq("noto_req_late", {31'd0, bus.imem_req}, 32'd1);
        ready_r = 1'b1;
        @(negedge clk);
        check_eq("noto_capture", instr, 32'hDEAD_BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
